// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB, stall/flush and issue bundle between the ALU reservation station
// and its neighbours (slave = station side, master = dispatch/CDB/ALU side).
interface alu_reservation_station_if #(
  parameter int unsigned ROBsizeLog   = 6,
  parameter int unsigned RSentriesLog = 3
);
  logic                    flush_i;
  logic                    dispatchValid_i;
  logic [9:0]              dispatchCommands_i;
  logic [ROBsizeLog-1:0]   dispatchTag_i;
  logic [63:0]             dispatchVal1_i;
  logic                    dispatchRdy1_i;
  logic [ROBsizeLog-1:0]   dispatchSrc1_i;
  logic [63:0]             dispatchVal2_i;
  logic                    dispatchRdy2_i;
  logic [ROBsizeLog-1:0]   dispatchSrc2_i;
  logic                    rsFull_o;
  logic [RSentriesLog-1:0] rsCount_o;
  logic                    cdbValid_i;
  logic [ROBsizeLog-1:0]   cdbTag_i;
  logic [63:0]             cdbVal_i;
  logic                    stallRS_i;
  logic [63:0]             reservationStationVal1_o;
  logic [63:0]             reservationStationVal2_o;
  logic [9:0]              reservationStationCommands_o;
  logic [ROBsizeLog-1:0]   reservationStationTag_o;
  logic                    readyRS_o;

  modport slave (
    input  flush_i, dispatchValid_i, dispatchCommands_i, dispatchTag_i,
           dispatchVal1_i, dispatchRdy1_i, dispatchSrc1_i,
           dispatchVal2_i, dispatchRdy2_i, dispatchSrc2_i,
           cdbValid_i, cdbTag_i, cdbVal_i, stallRS_i,
    output rsFull_o, rsCount_o, reservationStationVal1_o, reservationStationVal2_o,
           reservationStationCommands_o, reservationStationTag_o, readyRS_o
  );

  modport master (
    output flush_i, dispatchValid_i, dispatchCommands_i, dispatchTag_i,
           dispatchVal1_i, dispatchRdy1_i, dispatchSrc1_i,
           dispatchVal2_i, dispatchRdy2_i, dispatchSrc2_i,
           cdbValid_i, cdbTag_i, cdbVal_i, stallRS_i,
    input  rsFull_o, rsCount_o, reservationStationVal1_o, reservationStationVal2_o,
           reservationStationCommands_o, reservationStationTag_o, readyRS_o
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive on the CDB,
// then issues the lowest-index ready op per unstalled cycle through a registered port.
module alu_reservation_station #(
  parameter int unsigned ROBsize      = 32,
  parameter int unsigned ROBsizeLog   = $clog2(ROBsize + 1),
  parameter int unsigned RSentries    = 4,
  parameter int unsigned RSentriesLog = $clog2(RSentries + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  alu_reservation_station_if.slave rs
);
  localparam int unsigned IDX_W = $clog2(RSentries);

  if (RSentries < 2 || (1 << IDX_W) != RSentries) begin : g_bad_entries
    $error("RSentries must be a power of two and at least 2");
  end
  if ((1 << ROBsizeLog) <= ROBsize) begin : g_bad_tag
    $error("ROBsizeLog too narrow for ROBsize");
  end

  logic [RSentries-1:0]  r_valid;
  logic [RSentries-1:0]  r_rdy1;
  logic [RSentries-1:0]  r_rdy2;
  logic [9:0]            r_cmd  [RSentries];
  logic [ROBsizeLog-1:0] r_tag  [RSentries];
  logic [63:0]           r_val1 [RSentries];
  logic [63:0]           r_val2 [RSentries];
  logic [ROBsizeLog-1:0] r_src1 [RSentries];
  logic [ROBsizeLog-1:0] r_src2 [RSentries];

  logic [RSentriesLog-1:0] r_count;
  logic                    r_ready;
  logic [63:0]             r_iss_val1;
  logic [63:0]             r_iss_val2;
  logic [9:0]              r_iss_cmd;
  logic [ROBsizeLog-1:0]   r_iss_tag;

  logic                 w_full;
  logic [RSentries-1:0] w_elig;
  logic                 w_has_sel;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_issue;
  logic                 w_disp;
  logic                 w_byp1;
  logic                 w_byp2;
  logic                 w_drdy1;
  logic                 w_drdy2;
  logic [63:0]          w_dval1;
  logic [63:0]          w_dval2;

  // Select uses start-of-cycle ready bits, so a same-edge wakeup waits a cycle.
  always_comb begin
    w_full     = &r_valid;
    w_elig     = r_valid & r_rdy1 & r_rdy2;
    w_has_sel  = |w_elig;
    w_sel_idx  = '0;
    w_free_idx = '0;
    for (int i = RSentries - 1; i >= 0; i--) begin
      if (w_elig[i])   w_sel_idx  = IDX_W'(i);
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
    w_issue = !rs.flush_i && !rs.stallRS_i && w_has_sel;
    w_disp  = !rs.flush_i && rs.dispatchValid_i && !w_full;
  end

  // Dispatch-cycle bypass from the CDB for operands that are not yet ready.
  always_comb begin
    w_byp1  = rs.cdbValid_i && !rs.dispatchRdy1_i && (rs.cdbTag_i == rs.dispatchSrc1_i);
    w_byp2  = rs.cdbValid_i && !rs.dispatchRdy2_i && (rs.cdbTag_i == rs.dispatchSrc2_i);
    w_drdy1 = rs.dispatchRdy1_i || w_byp1;
    w_drdy2 = rs.dispatchRdy2_i || w_byp2;
    w_dval1 = w_byp1 ? rs.cdbVal_i : rs.dispatchVal1_i;
    w_dval2 = w_byp2 ? rs.cdbVal_i : rs.dispatchVal2_i;
  end

  // Entry storage: wakeup, issue invalidate, then dispatch into a free slot.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      for (int i = 0; i < RSentries; i++) begin
        r_cmd[i]  <= '0;
        r_tag[i]  <= '0;
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_src1[i] <= '0;
        r_src2[i] <= '0;
      end
    end else if (rs.flush_i) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < RSentries; i++) begin
        if (r_valid[i] && rs.cdbValid_i) begin
          if (!r_rdy1[i] && (r_src1[i] == rs.cdbTag_i)) begin
            r_val1[i] <= rs.cdbVal_i;
            r_rdy1[i] <= 1'b1;
          end
          if (!r_rdy2[i] && (r_src2[i] == rs.cdbTag_i)) begin
            r_val2[i] <= rs.cdbVal_i;
            r_rdy2[i] <= 1'b1;
          end
        end
      end
      if (w_issue) r_valid[w_sel_idx] <= 1'b0;
      if (w_disp) begin
        r_valid[w_free_idx] <= 1'b1;
        r_cmd[w_free_idx]   <= rs.dispatchCommands_i;
        r_tag[w_free_idx]   <= rs.dispatchTag_i;
        r_val1[w_free_idx]  <= w_dval1;
        r_val2[w_free_idx]  <= w_dval2;
        r_rdy1[w_free_idx]  <= w_drdy1;
        r_rdy2[w_free_idx]  <= w_drdy2;
        r_src1[w_free_idx]  <= rs.dispatchSrc1_i;
        r_src2[w_free_idx]  <= rs.dispatchSrc2_i;
      end
    end
  end

  // Issue register: data holds when idle or stalled; flush drops the valid bit.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_ready    <= 1'b0;
      r_iss_val1 <= '0;
      r_iss_val2 <= '0;
      r_iss_cmd  <= '0;
      r_iss_tag  <= '0;
    end else if (rs.flush_i) begin
      r_ready <= 1'b0;
    end else if (!rs.stallRS_i) begin
      r_ready <= w_has_sel;
      if (w_has_sel) begin
        r_iss_val1 <= r_val1[w_sel_idx];
        r_iss_val2 <= r_val2[w_sel_idx];
        r_iss_cmd  <= r_cmd[w_sel_idx];
        r_iss_tag  <= r_tag[w_sel_idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else if (rs.flush_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + RSentriesLog'(w_disp) - RSentriesLog'(w_issue);
    end
  end

  assign rs.rsFull_o                     = w_full;
  assign rs.rsCount_o                    = r_count;
  assign rs.readyRS_o                    = r_ready;
  assign rs.reservationStationVal1_o     = r_iss_val1;
  assign rs.reservationStationVal2_o     = r_iss_val2;
  assign rs.reservationStationCommands_o = r_iss_cmd;
  assign rs.reservationStationTag_o      = r_iss_tag;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: issue latency, wakeup, bypass, full,
// priority, stall, flush and asynchronous reset, with hand-computed expectations.
module tb_alu_reservation_station;
  localparam int unsigned TAGW = 6;
  localparam int unsigned CNTW = 3;

  logic clk_i = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   failures = 0;

  alu_reservation_station_if #(.ROBsizeLog(TAGW), .RSentriesLog(CNTW)) bus ();

  alu_reservation_station #(.ROBsize(32), .RSentries(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rs      (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic disp(input logic [9:0] cmd, input logic [TAGW-1:0] tag,
                      input logic [63:0] v1, input logic r1, input logic [TAGW-1:0] s1,
                      input logic [63:0] v2, input logic r2, input logic [TAGW-1:0] s2);
    bus.dispatchValid_i    = 1'b1;
    bus.dispatchCommands_i = cmd;
    bus.dispatchTag_i      = tag;
    bus.dispatchVal1_i     = v1;
    bus.dispatchRdy1_i     = r1;
    bus.dispatchSrc1_i     = s1;
    bus.dispatchVal2_i     = v2;
    bus.dispatchRdy2_i     = r2;
    bus.dispatchSrc2_i     = s2;
  endtask

  task automatic cdb(input logic v, input logic [TAGW-1:0] tag, input logic [63:0] val);
    bus.cdbValid_i = v;
    bus.cdbTag_i   = tag;
    bus.cdbVal_i   = val;
  endtask

  task automatic issue_chk(input string tag, input logic [TAGW-1:0] etag, input logic [63:0] v1,
                           input logic [63:0] v2, input logic [9:0] cmd);
    chk({tag, "_ready"}, 64'(bus.readyRS_o), 64'd1);
    chk({tag, "_tag"},   64'(bus.reservationStationTag_o), 64'(etag));
    chk({tag, "_val1"},  bus.reservationStationVal1_o, v1);
    chk({tag, "_val2"},  bus.reservationStationVal2_o, v2);
    chk({tag, "_cmd"},   64'(bus.reservationStationCommands_o), 64'(cmd));
  endtask

  initial begin
    reset_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.stallRS_i = 1'b0;
    disp(10'd0, '0, 64'd0, 1'b0, '0, 64'd0, 1'b0, '0);
    bus.dispatchValid_i = 1'b0;
    cdb(1'b0, '0, 64'd0);
    #2;
    chk("rst_ready", 64'(bus.readyRS_o), 64'd0);
    chk("rst_count", 64'(bus.rsCount_o), 64'd0);
    chk("rst_full",  64'(bus.rsFull_o), 64'd0);
    chk("rst_val1",  bus.reservationStationVal1_o, 64'd0);
    #10;
    reset_i = 1'b1;

    // Both operands ready: issue after the following edge.
    disp(10'd10, 6'd3, 64'd15, 1'b1, '0, 64'd3, 1'b1, '0);
    tick();
    bus.dispatchValid_i = 1'b0;
    chk("d1_count", 64'(bus.rsCount_o), 64'd1);
    chk("d1_notyet", 64'(bus.readyRS_o), 64'd0);
    tick();
    issue_chk("d1_iss", 6'd3, 64'd15, 64'd3, 10'd10);
    chk("d1_count0", 64'(bus.rsCount_o), 64'd0);

    // Operand 1 waits for tag 7 on the CDB.
    disp(10'd1, 6'd5, 64'd0, 1'b0, 6'd7, 64'd4, 1'b1, '0);
    tick();
    bus.dispatchValid_i = 1'b0;
    chk("wk_wait0", 64'(bus.readyRS_o), 64'd0);
    tick();
    chk("wk_wait1", 64'(bus.readyRS_o), 64'd0);
    cdb(1'b1, 6'd7, 64'd100);
    tick();
    cdb(1'b0, '0, 64'd0);
    chk("wk_sameedge", 64'(bus.readyRS_o), 64'd0);
    tick();
    issue_chk("wk_iss", 6'd5, 64'd100, 64'd4, 10'd1);

    // Dispatch-cycle bypass on operand 2.
    disp(10'd2, 6'd6, 64'd1, 1'b1, '0, 64'd0, 1'b0, 6'd9);
    cdb(1'b1, 6'd9, 64'hDEAD);
    tick();
    bus.dispatchValid_i = 1'b0;
    cdb(1'b0, '0, 64'd0);
    chk("byp_wait", 64'(bus.readyRS_o), 64'd0);
    tick();
    issue_chk("byp_iss", 6'd6, 64'd1, 64'hDEAD, 10'd2);

    // Fill four non-ready entries; even slots wait on tag 20, odd on tag 21.
    for (int i = 0; i < 4; i++) begin
      disp(10'(i), 6'(10 + i), 64'd0, 1'b0, (i % 2 == 0) ? 6'd20 : 6'd21,
           64'(100 + i), 1'b1, '0);
      tick();
    end
    chk("full_flag", 64'(bus.rsFull_o), 64'd1);
    chk("full_count", 64'(bus.rsCount_o), 64'd4);
    disp(10'd9, 6'd14, 64'd1, 1'b1, '0, 64'd2, 1'b1, '0);
    tick();
    bus.dispatchValid_i = 1'b0;
    chk("drop_count", 64'(bus.rsCount_o), 64'd4);
    chk("drop_ready", 64'(bus.readyRS_o), 64'd0);
    cdb(1'b1, 6'd20, 64'd77);
    tick();
    cdb(1'b0, '0, 64'd0);
    chk("pri_wake", 64'(bus.readyRS_o), 64'd0);
    tick();
    issue_chk("pri_e0", 6'd10, 64'd77, 64'd100, 10'd0);
    chk("pri_e0_count", 64'(bus.rsCount_o), 64'd3);
    chk("pri_notfull", 64'(bus.rsFull_o), 64'd0);
    tick();
    issue_chk("pri_e2", 6'd12, 64'd77, 64'd102, 10'd2);
    chk("pri_e2_count", 64'(bus.rsCount_o), 64'd2);
    tick();
    chk("pri_idle", 64'(bus.readyRS_o), 64'd0);

    // Wake entries 1 and 3; entry 1 issues, then stall with two ready entries queued.
    cdb(1'b1, 6'd21, 64'd55);
    tick();
    cdb(1'b0, '0, 64'd0);
    tick();
    issue_chk("st_e1", 6'd11, 64'd55, 64'd101, 10'd1);
    chk("st_e1_count", 64'(bus.rsCount_o), 64'd1);
    bus.stallRS_i = 1'b1;
    disp(10'd7, 6'd15, 64'd8, 1'b1, '0, 64'd9, 1'b1, '0);
    tick();
    bus.dispatchValid_i = 1'b0;
    chk("st_disp_count", 64'(bus.rsCount_o), 64'd2);
    tick();
    tick();
    issue_chk("st_hold", 6'd11, 64'd55, 64'd101, 10'd1);
    chk("st_hold_count", 64'(bus.rsCount_o), 64'd2);
    bus.stallRS_i = 1'b0;
    tick();
    issue_chk("st_rel", 6'd15, 64'd8, 64'd9, 10'd7);
    chk("st_rel_count", 64'(bus.rsCount_o), 64'd1);
    tick();
    issue_chk("st_e3", 6'd13, 64'd55, 64'd103, 10'd3);
    chk("st_e3_count", 64'(bus.rsCount_o), 64'd0);

    // Three entries under stall, then flush (overrides stall, drops a same-edge dispatch).
    bus.stallRS_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp(10'd4, 6'(30 + i), 64'(i), 1'b1, '0, 64'd1, 1'b1, '0);
      tick();
    end
    chk("fl_pre_count", 64'(bus.rsCount_o), 64'd3);
    chk("fl_pre_ready", 64'(bus.readyRS_o), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.dispatchValid_i = 1'b0;
    bus.stallRS_i = 1'b0;
    chk("fl_count", 64'(bus.rsCount_o), 64'd0);
    chk("fl_ready", 64'(bus.readyRS_o), 64'd0);
    tick();
    chk("fl_empty", 64'(bus.readyRS_o), 64'd0);

    // Asynchronous reset between edges after a fresh issue.
    disp(10'd3, 6'd2, 64'd5, 1'b1, '0, 64'd6, 1'b1, '0);
    tick();
    bus.dispatchValid_i = 1'b0;
    tick();
    issue_chk("ar_pre", 6'd2, 64'd5, 64'd6, 10'd3);
    #2;
    reset_i = 1'b0;
    #1;
    chk("ar_ready", 64'(bus.readyRS_o), 64'd0);
    chk("ar_val1",  bus.reservationStationVal1_o, 64'd0);
    chk("ar_tag",   64'(bus.reservationStationTag_o), 64'd0);
    chk("ar_count", 64'(bus.rsCount_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station that sits directly upstream of the ALU issue/execute stage.
- Accepts dispatched ALU ops whose operands are either values or pending ROB tags, and captures pending operands from the common data bus (CDB).
- Presents one ready op per cycle on a registered issue port that the ALU stage consumes.
- Honours that stage's stall (stallRS) handshake.

Parameters:
- ROBsize, 32, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), width of ROB tags.
- RSentries, 4, number of station entries (power of two, at least 2).
- RSentriesLog, $clog2(RSentries+1), width of the occupancy count.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous squash of all entries and the issue register.
- dispatchValid_i  in  1  dispatch request this cycle.
- dispatchCommands_i  in  10  op control word; bits [4:2] are the ALU control.
- dispatchTag_i  in  ROBsizeLog  destination ROB tag.
- dispatchVal1_i  in  64  operand 1 value, used when dispatchRdy1_i=1.
- dispatchRdy1_i  in  1  operand 1 is already available.
- dispatchSrc1_i  in  ROBsizeLog  producer tag for operand 1 when not ready.
- dispatchVal2_i, dispatchRdy2_i, dispatchSrc2_i  same as operand 1, for operand 2.
- rsFull_o  out  1  no free entry; dispatch is ignored.
- rsCount_o  out  RSentriesLog  number of valid entries.
- cdbValid_i  in  1  CDB broadcast valid.
- cdbTag_i  in  ROBsizeLog  broadcast ROB tag.
- cdbVal_i  in  64  broadcast result.
- stallRS_i  in  1  downstream not accepting; from the ALU stage's stallRS_o.
- reservationStationVal1_o  out  64  issued operand 1.
- reservationStationVal2_o  out  64  issued operand 2.
- reservationStationCommands_o  out  10  issued control word.
- reservationStationTag_o  out  ROBsizeLog  issued destination tag.
- readyRS_o  out  1  issue register holds a valid op.

Behaviour:
- Reset (reset_i low, asynchronous): all entries invalid. All issue-register outputs 0, readyRS_o=0, rsFull_o=0, rsCount_o=0.
- Entry state: valid, commands, tag, and for each operand a value, a ready bit and a source tag.
- rsFull_o = all entries valid. It is combinational from current state; no same-cycle credit for an entry issuing this edge.
- Dispatch: when dispatchValid_i=1 and rsFull_o=0, the request is written at the edge into the lowest-index invalid entry.
  - For each operand with rdy=0: if cdbValid_i=1 and cdbTag_i equals its src tag in the same cycle, the entry stores cdbVal_i and ready=1 (dispatch bypass). Otherwise the entry stores ready=0 and the src tag.
  - When rsFull_o=1, dispatch is dropped silently; the producer must hold it.
- Wakeup: each edge with cdbValid_i=1, every valid entry operand with ready=0 whose src tag equals cdbTag_i captures cdbVal_i and sets ready=1. Both operands may wake on the same broadcast.
- Select: an entry is eligible when valid and both ready bits are already set (state at the start of the cycle). Same-cycle wakeup is not selectable until the next cycle. The lowest-index eligible entry wins.
- Issue register (stallRS_i=0 at the edge):
  - Loads the selected entry's fields, sets readyRS_o=1 and invalidates that entry.
  - If nothing is eligible, readyRS_o=0 and the data fields hold their old values.
- stallRS_i=1: issue register and readyRS_o hold; no entry leaves the station. Dispatch and wakeup continue.
- Latency: dispatch with both operands ready at edge N appears on the issue port after edge N+1 (if unstalled). A CDB wakeup at edge N gives issue at edge N+1.
- Throughput: one issue per unstalled cycle.
- Simultaneous events: issue of entry k and dispatch in the same cycle do not interact. Dispatch targets a currently invalid entry, so it never overwrites k. The slot freed by k becomes visible the next cycle.
- rsCount_o = number of valid entries. It is updated at the edge: +1 on accepted dispatch, -1 on issue, net 0 when both occur.
- flush_i=1 at an edge: all entries invalid, readyRS_o=0, and dispatch/wakeup that edge ignored. flush_i overrides stallRS_i.
- Reset asserted mid-operation: immediate clear to the reset state regardless of the clock.

Test Plan:
- Reset, then dispatch cmd=10 tag=3 val1=15 val2=3 both rdy, stallRS_i=0 -> after the next edge readyRS_o=1, Val1=15, Val2=3, Commands=10, Tag=3; rsCount_o back to 0.
- Dispatch tag=5 with src1=7 not ready and val2=4 rdy -> readyRS_o stays 0. Broadcast cdbTag=7 cdbVal=100 -> issue one edge later with Val1=100, Val2=4.
- Dispatch with src2=9 while cdbValid=1 cdbTag=9 cdbVal=0xDEAD the same cycle -> bypass captured; op issues next edge with Val2=0xDEAD.
- Fill all 4 entries as non-ready, then attempt a 5th dispatch -> rsFull_o=1, 5th dropped, rsCount_o=4. Broadcast wakes entries 2 and 0 -> entry 0 issues first, then entry 2.
- Hold stallRS_i=1 for 3 cycles with two ready entries -> outputs and readyRS_o stay constant and rsCount_o is unchanged. Release -> the second op issues on the following edge.
- With 3 valid entries and readyRS_o=1, pulse flush_i -> rsCount_o=0, readyRS_o=0. Assert reset_i low between edges -> outputs clear immediately.
